// File: rtl/fb_sdram_scheduler.sv
// Frame-buffer SDRAM port scheduler: one fixed burst at a time, read underflow priority (FB_DOUBLE_BUFFER_EN adds ping-pong banks).
// Latency: cmd_valid 1 cycle after the IDLE decision; at least 1 idle cycle between burst_done and the next command.
// Backpressure: command held stable while cmd_ready is low; no new selection until burst_done.
module fb_sdram_scheduler #(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned LVL_W       = 10,
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned RD_URGENT   = 128,
  parameter int unsigned BANK1_BASE  = 524288
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LVL_W-1:0]  wr_fifo_level,
  input  logic [LVL_W-1:0]  rd_fifo_level,
  input  logic              cam_frame_start,
  input  logic              vga_frame_start,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              burst_done,
  output logic              busy,
  output logic              frame_drop
);

  localparam logic [LVL_W-1:0]  RD_ELIG_MAX = LVL_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [LVL_W-1:0]  WR_ELIG_MIN = LVL_W'(BURST_LEN);
  localparam logic [LVL_W-1:0]  RD_URG_LVL  = LVL_W'(RD_URGENT);
  localparam logic [ADDR_W-1:0] BURST_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] FRAME_END   = ADDR_W'(FRAME_WORDS);

  // Pointer wrap compares for equality, so a frame must hold whole bursts.
  if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_frame_multiple
    $error("FRAME_WORDS must be an exact multiple of BURST_LEN");
  end
  if (BANK1_BASE < FRAME_WORDS) begin : g_bank_overlap
    $error("BANK1_BASE must not overlap the first frame buffer");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] wr_base, rd_base, wr_nxt, rd_nxt, wr_addr, rd_addr;
  logic              wr_realign_q, rd_realign_q, rr_last_q;
  logic              rd_eligible, wr_eligible, rd_urgent, wr_wrap, rd_wrap;
  logic              pick_vld, pick_write;

  // A pending realign takes effect before selection in the same IDLE cycle.
  assign wr_base = wr_realign_q ? '0 : wr_ptr_q;
  assign rd_base = rd_realign_q ? '0 : rd_ptr_q;

  assign rd_eligible = rd_fifo_level <= RD_ELIG_MAX;
  assign wr_eligible = wr_fifo_level >= WR_ELIG_MIN;
  assign rd_urgent   = rd_fifo_level <  RD_URG_LVL;

  assign wr_wrap = (wr_ptr_q + BURST_STEP) == FRAME_END;
  assign rd_wrap = (rd_ptr_q + BURST_STEP) == FRAME_END;
  assign wr_nxt  = wr_wrap ? '0 : wr_ptr_q + BURST_STEP;
  assign rd_nxt  = rd_wrap ? '0 : rd_ptr_q + BURST_STEP;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic [ADDR_W-1:0] BANK1_OFS = ADDR_W'(BANK1_BASE);

  logic wr_bank_q, rd_bank_q, rd_bank_eff;

  // Bank only toggles on wrap, so the opposite bank is always the last completed frame.
  assign rd_bank_eff = rd_realign_q ? ~wr_bank_q : rd_bank_q;
  assign wr_addr     = (wr_bank_q   ? BANK1_OFS : '0) + wr_base;
  assign rd_addr     = (rd_bank_eff ? BANK1_OFS : '0) + rd_base;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b1;
    end else begin
      if (state_q == IDLE && rd_realign_q) rd_bank_q <= ~wr_bank_q;
      if (state_q == WAIT_DONE && burst_done && cmd_write && wr_wrap) wr_bank_q <= ~wr_bank_q;
    end
  end
`else
  assign wr_addr = wr_base;
  assign rd_addr = rd_base;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pick_vld   = 1'b0;
    pick_write = 1'b0;
    cmd_valid  = 1'b0;
    busy       = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (rd_urgent && rd_eligible) begin
          pick_vld   = 1'b1;
          pick_write = 1'b0;
        end else if (rd_eligible && wr_eligible) begin
          pick_vld   = 1'b1;
          pick_write = ~rr_last_q;
        end else if (wr_eligible || rd_eligible) begin
          pick_vld   = 1'b1;
          pick_write = wr_eligible;
        end
        if (pick_vld) state_d = ISSUE;
      end
      ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (burst_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      wr_realign_q <= 1'b0;
      rd_realign_q <= 1'b0;
      rr_last_q    <= 1'b0;
      cmd_write    <= 1'b0;
      cmd_addr     <= '0;
      frame_drop   <= 1'b0;
    end else begin
      frame_drop   <= cam_frame_start && (wr_ptr_q != '0) && !wr_realign_q;
      wr_realign_q <= cam_frame_start || (wr_realign_q && state_q != IDLE);
      rd_realign_q <= vga_frame_start || (rd_realign_q && state_q != IDLE);
      if (state_q == IDLE) begin
        wr_ptr_q <= wr_base;
        rd_ptr_q <= rd_base;
        if (pick_vld) begin
          cmd_write <= pick_write;
          cmd_addr  <= pick_write ? wr_addr : rd_addr;
          rr_last_q <= pick_write;
        end
      end
      // A coincident frame start leaves its realign pending, so the zeroing wins next IDLE.
      if (state_q == WAIT_DONE && burst_done) begin
        if (cmd_write) wr_ptr_q <= wr_nxt;
        else           rd_ptr_q <= rd_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fb_sdram_scheduler.sv
// Bench for fb_sdram_scheduler: directed + randomized bursts against a transaction-level model of the arbitration rules.
module tb_fb_sdram_scheduler;

  localparam int ADDR_W      = 22;
  localparam int LVL_W       = 10;
  localparam int BURST_LEN   = 256;
  localparam int FIFO_DEPTH  = 512;
  localparam int FRAME_WORDS = 307200;
  localparam int RD_URGENT   = 128;
  localparam int BANK1_BASE  = 524288;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [LVL_W-1:0]  wr_fifo_level, rd_fifo_level;
  logic              cam_frame_start, vga_frame_start;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic              burst_done, busy, frame_drop;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int m_wr_ptr, m_rd_ptr, m_wr_bank, m_rd_bank, m_done_bank;
  bit m_rr_last_wr, m_wr_pend, m_rd_pend;

  always #5 clk_i = ~clk_i;

  fb_sdram_scheduler #(
    .ADDR_W(ADDR_W), .LVL_W(LVL_W), .BURST_LEN(BURST_LEN), .FIFO_DEPTH(FIFO_DEPTH),
    .FRAME_WORDS(FRAME_WORDS), .RD_URGENT(RD_URGENT), .BANK1_BASE(BANK1_BASE)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wr_fifo_level(wr_fifo_level), .rd_fifo_level(rd_fifo_level),
    .cam_frame_start(cam_frame_start), .vga_frame_start(vga_frame_start),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .burst_done(burst_done), .busy(busy), .frame_drop(frame_drop)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_ptr = 0; m_rd_ptr = 0; m_rr_last_wr = 0; m_wr_pend = 0; m_rd_pend = 0;
    m_wr_bank = 0; m_rd_bank = 1; m_done_bank = 1;
  endtask

  // 0 = nothing, 1 = read, 2 = write
  function automatic int predict(input int rdl, input int wrl);
    bit rde = (rdl <= FIFO_DEPTH - BURST_LEN);
    bit wre = (wrl >= BURST_LEN);
    if (rde && rdl < RD_URGENT) return 1;
    if (rde && wre) return m_rr_last_wr ? 1 : 2;
    if (wre) return 2;
    if (rde) return 1;
    return 0;
  endfunction

  function automatic int addr_of(input int bank, input int ptr);
    return (DBUF ? bank * BANK1_BASE : 0) + ptr;
  endfunction

  task automatic run_burst(input string tag, input int rdy_dly, input int done_dly,
                           input bit cam_p, input bit vga_p, input bit with_done,
                           output int gap, output bit obs_wr);
    int  kind, exp_addr;
    bit  drop_exp;
    if (m_wr_pend) begin m_wr_ptr = 0; m_wr_pend = 0; end
    if (m_rd_pend) begin m_rd_ptr = 0; m_rd_pend = 0; m_rd_bank = m_done_bank; end
    kind     = predict(int'(rd_fifo_level), int'(wr_fifo_level));
    exp_addr = (kind == 2) ? addr_of(m_wr_bank, m_wr_ptr) : addr_of(m_rd_bank, m_rd_ptr);
    drop_exp = 1'b0;
    gap      = 0;
    obs_wr   = cmd_write;
    while (cmd_valid !== 1'b1 && gap < 50) begin
      @(negedge clk_i);
      gap++;
    end
    check({tag, " cmd_valid"}, cmd_valid, 1);
    if (cmd_valid !== 1'b1) return;
    obs_wr = cmd_write;
    check({tag, " cmd_write"}, cmd_write, (kind == 2));
    check({tag, " cmd_addr"}, cmd_addr, exp_addr);
    check({tag, " busy"}, busy, 1);
    repeat (rdy_dly) begin
      @(negedge clk_i);
      check({tag, " held valid"}, cmd_valid, 1);
      check({tag, " held addr"}, cmd_addr, exp_addr);
    end
    cmd_ready = 1'b1;
    @(negedge clk_i);
    cmd_ready = 1'b0;
    check({tag, " valid drop"}, cmd_valid, 0);
    check({tag, " busy wait"}, busy, 1);
    m_rr_last_wr = (kind == 2);
    repeat (done_dly) @(negedge clk_i);
    if ((cam_p || vga_p) && !with_done) begin
      cam_frame_start = cam_p;
      vga_frame_start = vga_p;
      drop_exp = cam_p && (m_wr_ptr != 0) && !m_wr_pend;
      if (cam_p) m_wr_pend = 1;
      if (vga_p) m_rd_pend = 1;
      @(negedge clk_i);
      cam_frame_start = 1'b0;
      vga_frame_start = 1'b0;
      check({tag, " frame_drop"}, frame_drop, drop_exp);
      check({tag, " busy pulse"}, busy, 1);
    end
    burst_done = 1'b1;
    if ((cam_p || vga_p) && with_done) begin
      cam_frame_start = cam_p;
      vga_frame_start = vga_p;
      drop_exp = cam_p && (m_wr_ptr != 0) && !m_wr_pend;
      if (cam_p) m_wr_pend = 1;
      if (vga_p) m_rd_pend = 1;
    end
    @(negedge clk_i);
    burst_done = 1'b0;
    cam_frame_start = 1'b0;
    vga_frame_start = 1'b0;
    if ((cam_p || vga_p) && with_done) check({tag, " frame_drop"}, frame_drop, drop_exp);
    else                               check({tag, " no drop"}, frame_drop, 0);
    check({tag, " busy done"}, busy, 0);
    if (kind == 2) begin
      m_wr_ptr += BURST_LEN;
      if (m_wr_ptr >= FRAME_WORDS) begin
        m_wr_ptr -= FRAME_WORDS;
        m_done_bank = m_wr_bank;
        m_wr_bank = 1 - m_wr_bank;
      end
    end else begin
      m_rd_ptr = (m_rd_ptr + BURST_LEN) % FRAME_WORDS;
    end
  endtask

  initial begin
    int gap, k, rdl, wrl;
    bit ow, pul;
    rst_ni = 1'b0;
    wr_fifo_level = '0; rd_fifo_level = '0;
    cam_frame_start = 1'b0; vga_frame_start = 1'b0;
    cmd_ready = 1'b0; burst_done = 1'b0;
    model_reset();

    repeat (100) begin
      @(negedge clk_i);
      check("reset cmd_valid", cmd_valid, 0);
      check("reset busy", busy, 0);
    end
    check("reset cmd_addr", cmd_addr, 0);
    check("reset cmd_write", cmd_write, 0);
    check("reset frame_drop", frame_drop, 0);

    rd_fifo_level = 10'd300; wr_fifo_level = 10'd100;
    rst_ni = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      check("none eligible", cmd_valid, 0);
    end

    rd_fifo_level = 10'd0; wr_fifo_level = 10'd0;
    run_burst("first read", 5, 2, 0, 0, 0, gap, ow);
    check("first read gap", gap, 1);
    run_burst("second read", 0, 1, 0, 0, 0, gap, ow);
    check("back-to-back gap", gap, 1);

    rd_fifo_level = 10'd200; wr_fifo_level = 10'd300;
    for (int i = 0; i < 3; i++) begin
      run_burst("round robin", 0, 0, 0, 0, 0, gap, ow);
      check("round robin order", ow, (i % 2 == 0));
    end
    rd_fifo_level = 10'd100;
    run_burst("urgent read", 1, 0, 0, 0, 0, gap, ow);
    check("urgent is read", ow, 0);

    for (int i = 0; i < 60; i++) begin
      rdl = $urandom_range(0, 400);
      wrl = $urandom_range(0, 400);
      if (predict(rdl, wrl) == 0) rdl = $urandom_range(0, 256);
      rd_fifo_level = LVL_W'(rdl);
      wr_fifo_level = LVL_W'(wrl);
      pul = ($urandom_range(0, 5) == 0);
      run_burst("random", $urandom_range(0, 3), $urandom_range(0, 4),
                pul && ($urandom_range(0, 1) == 1), pul && ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1), gap, ow);
    end

    // Realign the writer, climb to 1024, then a frame start mid-burst.
    rd_fifo_level = 10'd300; wr_fifo_level = 10'd300;
    run_burst("cam realign", 0, 1, 1, 0, 1, gap, ow);
    for (int i = 0; i < 4; i++) run_burst("write climb", 0, 0, 0, 0, 0, gap, ow);
    check("model at 1024", m_wr_ptr, 1024);
    run_burst("cam mid burst", 0, 2, 1, 0, 0, gap, ow);

    for (int i = 0; i < FRAME_WORDS / BURST_LEN; i++)
      run_burst("frame write", 0, 0, 0, (i == FRAME_WORDS / BURST_LEN - 1), 0, gap, ow);
    rd_fifo_level = 10'd0;
    run_burst("read after frame", 0, 0, 0, 0, 0, gap, ow);
    check("read after frame addr", cmd_addr, 0);
    rd_fifo_level = 10'd300;
    run_burst("write after frame", 0, 0, 0, 0, 0, gap, ow);
    check("write after frame addr", cmd_addr, DBUF ? BANK1_BASE : 0);

    // Reset in the middle of a burst.
    rd_fifo_level = 10'd0;
    k = 0;
    while (cmd_valid !== 1'b1 && k < 50) begin @(negedge clk_i); k++; end
    check("pre-reset valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    @(negedge clk_i);
    cmd_ready = 1'b0;
    rst_ni = 1'b0;
    #1;
    check("midreset busy", busy, 0);
    check("midreset valid", cmd_valid, 0);
    check("midreset addr", cmd_addr, 0);
    check("midreset write", cmd_write, 0);
    rd_fifo_level = 10'd300; wr_fifo_level = 10'd0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();

    // Strobes outside their states must be ignored.
    burst_done = 1'b1; cmd_ready = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("stray strobes idle", busy, 0);
    end
    burst_done = 1'b0; cmd_ready = 1'b0;
    rd_fifo_level = 10'd0;
    run_burst("post reset read", 0, 0, 0, 0, 0, gap, ow);
    run_burst("post reset read2", 0, 0, 0, 0, 0, gap, ow);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
